// File: rtl/proto_field_encoder_if.sv
// Field/payload/output byte bundle for the protobuf field encoder.
// master = upstream + downstream side, slave = encoder side.
interface proto_field_encoder_if #(
  parameter int FIELD_NUM_W = 4,
  parameter int VALUE_W     = 64
);
  logic                   fld_valid;
  logic                   fld_ready;
  logic [FIELD_NUM_W-1:0] fld_num;
  logic [2:0]             fld_wtype;
  logic [VALUE_W-1:0]     fld_value;
  logic                   pl_valid;
  logic                   pl_ready;
  logic [7:0]             pl_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [7:0]             out_data;
  logic                   out_last;
  logic                   err;

  modport master (
    output fld_valid, fld_num, fld_wtype, fld_value,
    output pl_valid, pl_data, out_ready,
    input  fld_ready, pl_ready, out_valid, out_data,
    input  out_last, err
  );

  modport slave (
    input  fld_valid, fld_num, fld_wtype, fld_value,
    input  pl_valid, pl_data, out_ready,
    output fld_ready, pl_ready, out_valid, out_data,
    output out_last, err
  );
endinterface

// File: rtl/proto_field_encoder.sv
// Protobuf field serializer: key varint, then varint/fixed value or length+payload.
// Ports: clk, rst (sync, active high), bus (slave modport: fld_*, pl_*, out_*, err).
module proto_field_encoder #(
  parameter int FIELD_NUM_W = 4,
  parameter int VALUE_W     = 64
) (
  input logic                  clk,
  input logic                  rst,
  proto_field_encoder_if.slave bus
);
  localparam int KW  = FIELD_NUM_W + 3;
  // Key register padded to whole 7-bit groups so [6:0] always exists.
  localparam int KPW = ((KW + 6) / 7) * 7;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_KEY     = 3'd1;
  localparam logic [2:0] S_VARINT  = 3'd2;
  localparam logic [2:0] S_FIXED   = 3'd3;
  localparam logic [2:0] S_PAYLOAD = 3'd4;

  logic [2:0]         state;
  logic [2:0]         wtype;
  logic [2:0]         ty;
  logic [KPW-1:0]     key_sr;
  logic [KPW-1:0]     key_cur;
  logic [KPW-1:0]     key_nxt;
  logic [VALUE_W-1:0] val_sr;
  logic [VALUE_W-1:0] val_nxt;
  logic [VALUE_W-1:0] cnt;
  logic               fin;
  logic               ov;
  logic               ol;
  logic               er;
  logic [7:0]         od;
  logic               can_load;
  logic               fld_hs;
  logic               pl_hs;
  logic               key_go;
  logic               key_last;
  logic               ty_ok;
  logic               ty_var;
  logic               ty_f64;

  assign bus.fld_ready = (state == S_IDLE) && !rst;
  // fin: final byte already loaded, waiting for its handshake.
  assign bus.pl_ready  = (state == S_PAYLOAD) && !fin && can_load;
  assign bus.out_valid = ov;
  assign bus.out_data  = od;
  assign bus.out_last  = ol;
  assign bus.err       = er;

  always_comb begin
    can_load = !ov || bus.out_ready;
    fld_hs   = bus.fld_valid && bus.fld_ready;
    pl_hs    = bus.pl_valid && bus.pl_ready;
    ty       = (state == S_IDLE) ? bus.fld_wtype : wtype;
    ty_ok    = 1'b0;
    ty_var   = 1'b0;
    ty_f64   = 1'b0;
    unique case (1'b1)
      ty == 3'd0, ty == 3'd2: begin
        ty_ok  = 1'b1;
        ty_var = 1'b1;
      end
      ty == 3'd1: begin
        ty_ok  = 1'b1;
        ty_f64 = 1'b1;
      end
      ty == 3'd5: ty_ok = 1'b1;
      default: ;
    endcase
    // First key byte goes out straight from the descriptor.
    key_cur  = (state == S_IDLE)
             ? KPW'({bus.fld_num, bus.fld_wtype})
             : key_sr;
    key_nxt  = key_cur >> 7;
    key_last = (key_nxt == '0);
    key_go   = (fld_hs && ty_ok)
             || (state == S_KEY && can_load);
    val_nxt  = val_sr >> 7;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      wtype  <= '0;
      key_sr <= '0;
      val_sr <= '0;
      cnt    <= '0;
      fin    <= 1'b0;
      ov     <= 1'b0;
      od     <= '0;
      ol     <= 1'b0;
      er     <= 1'b0;
    end else begin
      er <= 1'b0;
      if (ov && bus.out_ready) begin
        ov <= 1'b0;
        ol <= 1'b0;
        if (fin) begin
          fin   <= 1'b0;
          state <= S_IDLE;
        end
      end
      if (fld_hs) begin
        if (ty_ok) begin
          wtype  <= bus.fld_wtype;
          val_sr <= bus.fld_value;
          cnt    <= bus.fld_value;
        end else begin
          er <= 1'b1;
        end
      end
      if (key_go) begin
        ov     <= 1'b1;
        od     <= {!key_last, key_cur[6:0]};
        ol     <= 1'b0;
        key_sr <= key_nxt;
        if (!key_last) begin
          state <= S_KEY;
        end else if (ty_var) begin
          state <= S_VARINT;
        end else begin
          state <= S_FIXED;
          cnt   <= ty_f64 ? VALUE_W'(8) : VALUE_W'(4);
        end
      end
      if (state == S_VARINT && can_load && !fin) begin
        ov     <= 1'b1;
        od     <= {val_nxt != '0, val_sr[6:0]};
        val_sr <= val_nxt;
        if (val_nxt == '0) begin
          // cnt still holds the length for type 2.
          if (wtype == 3'd0 || cnt == '0) begin
            ol  <= 1'b1;
            fin <= 1'b1;
          end else begin
            state <= S_PAYLOAD;
          end
        end
      end
      if (state == S_FIXED && can_load && !fin) begin
        ov     <= 1'b1;
        od     <= val_sr[7:0];
        val_sr <= val_sr >> 8;
        cnt    <= cnt - VALUE_W'(1);
        if (cnt == VALUE_W'(1)) begin
          ol  <= 1'b1;
          fin <= 1'b1;
        end
      end
      if (pl_hs) begin
        ov  <= 1'b1;
        od  <= bus.pl_data;
        cnt <= cnt - VALUE_W'(1);
        if (cnt == VALUE_W'(1)) begin
          ol  <= 1'b1;
          fin <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/proto_field_encoder.md
# proto_field_encoder

Streaming protobuf wire-format serializer: takes one field per transaction (field number, wire type, value) and emits its encoded bytes, key varint then value, on a byte stream with valid/ready backpressure. It is the transmit counterpart of the message-tree decoder. Upstream logic walks the same field metadata (identifier, data type, embedded-message flag) and presents fields in order. For length-delimited fields the block emits key and length, then forwards exactly `length` raw payload bytes from a separate byte input.

## Interface
- `FIELD_NUM_W`, default 4: field-number width. The key varint is ceil((FIELD_NUM_W+3)/7) bytes max.
- `VALUE_W`, default 64: value width. Must be 64; the top bits are ignored for fixed32.
- `clk` in, 1: single clock.
- `rst` in, 1: synchronous, active-high reset.
- `fld_valid` in, 1: field descriptor valid.
- `fld_ready` out, 1: block accepts the descriptor; high only in IDLE.
- `fld_num` in, FIELD_NUM_W: protobuf field number.
- `fld_wtype` in, 3: wire type. 0 = varint, 1 = fixed64, 2 = length-delimited, 5 = fixed32.
- `fld_value` in, VALUE_W: value. For wire type 2 this is the payload length in bytes.
- `pl_valid` in, 1: payload byte valid. Used only in the PAYLOAD state.
- `pl_ready` out, 1: payload byte accepted.
- `pl_data` in, 8: raw payload byte.
- `out_valid` out, 1: output byte valid.
- `out_ready` in, 1: downstream accepts the byte.
- `out_data` out, 8: encoded byte.
- `out_last` out, 1: marks the final byte of the current field.
- `err` out, 1: one-cycle pulse when an unsupported wire type is accepted.

## Operation
- Key = (fld_num << 3) | fld_wtype. It is encoded as a varint.
- Varint rule: emit value[6:0], with bit 7 = 1 if (value >> 7) != 0. Shift right by 7 and repeat until the remainder is 0. Value 0 encodes as the single byte 0x00. A 64-bit value takes at most 10 bytes.
- State machine:
  - IDLE: fld_ready=1. On fld_valid, latch num, type and value. For types 0, 1, 2, 5 go to KEY. For types 3, 4, 6, 7 pulse err, emit nothing and stay in IDLE.
  - KEY: emit key varint bytes. After the last key byte: type 0 or 2 go to VARINT; type 1 or 5 go to FIXED with byte counter = 8 or 4.
  - VARINT: emit the value varint (the length, for type 2). After the last byte: type 0 goes to IDLE with out_last on that byte. Type 2 with length 0 goes to IDLE with out_last on the length byte. Type 2 with length > 0 goes to PAYLOAD with remaining count = length.
  - FIXED: emit value little-endian, LS byte first, for 4 or 8 bytes. out_last on the final byte, then go to IDLE.
  - PAYLOAD: forward pl_data to out_data and decrement the count on each accepted payload byte. out_last on the byte when count hits 0, then go to IDLE.
- Byte counters and the shifted value are internal registers. The count width covers VALUE_W bits of length.
- err does not block further fields.

## Timing
- Reset values: fld_ready=0 during reset and 1 the cycle after. out_valid=0, out_data=0, out_last=0, pl_ready=0, err=0. State = IDLE.
- `out_*` are registered. Once out_valid=1, out_data and out_last hold stable until out_valid && out_ready.
- First key byte: out_valid rises the cycle after the fld_valid && fld_ready handshake.
- Throughput is one byte per cycle while out_ready=1.
- One IDLE cycle follows each field's last-byte handshake before the next descriptor is accepted.
- pl_ready = (state==PAYLOAD) && (!out_valid || out_ready). A payload byte moves to the output register in the same cycle it is accepted.
- pl_ready stays 0 after the last payload byte is captured. Extra pl_valid is ignored until the next type-2 field.
- Reset mid-field: the field is abandoned, no further bytes are emitted, and the outputs take their reset values on the next edge.
- err asserts the cycle after the handshake, for 1 cycle. fld_ready is 1 again that same cycle.

## Test plan
- Field 1, type 0, value 150 -> out 0x08, 0x96, 0x01; out_last only on 0x01; 3 bytes on 3 consecutive cycles with out_ready=1.
- Field 2, type 5, value 0x12345678 -> 0x15, 0x78, 0x56, 0x34, 0x12; last on 0x12. Field 15, type 1, value 0x0102030405060708 -> 0x79, then 0x08 down to 0x01.
- Field 4, type 2, length 3, payload 0x61 0x62 0x63 -> 0x22, 0x03, 0x61, 0x62, 0x63; last on 0x63; pl_ready low afterwards. Length 0 -> 0x22, 0x00 with last on 0x00.
- Field 1, type 0, value 2^64-1 -> 0x08, nine 0xFF, then 0x01 (11 bytes). Value 0 -> 0x08, 0x00.
- Random out_ready and pl_valid throttling on the scenarios above -> identical byte sequence; out_data stable while out_valid && !out_ready; no byte lost or duplicated.
- Wire type 3 -> err pulse, no output bytes, fld_ready back the next cycle. Assert rst after 2 bytes of a fixed64 field -> out_valid=0 next cycle; a subsequent field encodes cleanly.
